// File: rtl/bullet_pkg.sv
// Shared types for the bullet pool controller: facing, per-slot lifecycle, controller states.
// No logic; types and widths only.
// No flow control; pure declarations.
package bullet_pkg;

    typedef enum logic [1:0] {
        LEFT  = 2'b00,
        RIGHT = 2'b01,
        DOWN  = 2'b10,
        UP    = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        FREE      = 2'd0,
        LAUNCHING = 2'd1,
        FLYING    = 2'd2
    } slot_state_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIRE     = 2'd1,
        COOLDOWN = 2'd2
    } ctrl_state_t;

    localparam int TMO_W = 4;
    localparam int CD_W  = 8;

endpackage

// File: rtl/rr_free_picker.sv
// Round-robin picker: first set bit of free_mask at or after ptr, wrapping.
// Combinational, zero latency.
// No backpressure; grant_vld low when the mask is empty.
module rr_free_picker #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     free_mask,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             grant_vld
);

    // Upper pass covers [ptr, N-1], lower pass wraps to [0, ptr-1].
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!grant_vld && (i >= int'(ptr)) && free_mask[i]) begin
                grant[i]  = 1'b1;
                grant_vld = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!grant_vld && (i < int'(ptr)) && free_mask[i]) begin
                grant[i]  = 1'b1;
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bullet_pool_ctrl.sv
// Bullet pool scheduler: fire -> one-frame round-robin shoot pulse, refire cooldown, slot lifecycle.
// Latency: shoot/fire_ack registered one edge after the request; slots_free combinational.
// Backpressure: requests during FIRE/COOLDOWN are ignored; no FREE slot gives fire_dropped. Option: BULLET_AUTOFIRE_EN.
module bullet_pool_ctrl
    import bullet_pkg::*;
#(
    parameter int NUM_SLOTS       = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int LAUNCH_TIMEOUT  = 4,
    localparam int FREE_W         = $clog2(NUM_SLOTS + 1),
    localparam int PTR_W          = $clog2(NUM_SLOTS)
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic                 fire,
    input  logic [1:0]           Direction,
    input  logic [NUM_SLOTS-1:0] slot_carry,
    output logic [NUM_SLOTS-1:0] shoot,
    output logic [1:0]           shot_dir,
    output logic [FREE_W-1:0]    slots_free,
    output logic                 fire_ack,
    output logic                 fire_dropped
);

    ctrl_state_t            ctrl_q, ctrl_d;
    logic [CD_W-1:0]        cd_q, cd_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [NUM_SLOTS-1:0]   shoot_q, shoot_d;
    logic                   ack_q, ack_d;
    logic                   drop_q, drop_d;
    dir_t                   dir_q, dir_d;
    slot_state_t            slot_q [NUM_SLOTS];
    slot_state_t            slot_d [NUM_SLOTS];
    logic [TMO_W-1:0]       tmo_q  [NUM_SLOTS];
    logic [TMO_W-1:0]       tmo_d  [NUM_SLOTS];

    logic                   fire_req;
    logic                   drop_allow;
    logic [NUM_SLOTS-1:0]   free_mask;
    logic [NUM_SLOTS-1:0]   grant;
    logic                   grant_vld;

`ifdef BULLET_AUTOFIRE_EN
    // Level-triggered; a held fire on an empty pool reports the drop once per IDLE visit.
    logic drop_seen;

    assign fire_req   = fire;
    assign drop_allow = ~drop_seen;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            drop_seen <= 1'b0;
        end else if (ctrl_q != IDLE) begin
            drop_seen <= 1'b0;
        end else if (drop_d) begin
            drop_seen <= 1'b1;
        end
    end
`else
    logic fire_prev;

    assign fire_req   = fire & ~fire_prev;
    assign drop_allow = 1'b1;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            fire_prev <= 1'b0;
        end else begin
            fire_prev <= fire;
        end
    end
`endif

    always_comb begin
        free_mask  = '0;
        slots_free = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            free_mask[i] = (slot_q[i] == FREE);
            if (slot_q[i] == FREE) begin
                slots_free = slots_free + 1'b1;
            end
        end
    end

    rr_free_picker #(
        .N     (NUM_SLOTS),
        .PTR_W (PTR_W)
    ) u_picker (
        .free_mask (free_mask),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    always_comb begin
        ctrl_d  = ctrl_q;
        cd_d    = cd_q;
        ptr_d   = ptr_q;
        shoot_d = '0;
        ack_d   = 1'b0;
        drop_d  = 1'b0;
        dir_d   = dir_q;
        case (ctrl_q)
            IDLE: begin
                if (fire_req) begin
                    if (grant_vld) begin
                        shoot_d = grant;
                        ack_d   = 1'b1;
                        dir_d   = dir_t'(Direction);
                        ctrl_d  = FIRE;
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (grant[i]) begin
                                ptr_d = (i == NUM_SLOTS - 1) ? '0 : PTR_W'(i + 1);
                            end
                        end
                    end else begin
                        drop_d = drop_allow;
                    end
                end
            end
            FIRE: begin
                cd_d   = CD_W'(COOLDOWN_FRAMES);
                ctrl_d = COOLDOWN;
            end
            COOLDOWN: begin
                if (cd_q <= CD_W'(1)) begin
                    cd_d   = '0;
                    ctrl_d = IDLE;
                end else begin
                    cd_d = cd_q - 1'b1;
                end
            end
            default: ctrl_d = IDLE;
        endcase
    end

    // A slot granted this edge starts launching; carry drop confirms flight, carry return frees it.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_d[i] = slot_q[i];
            tmo_d[i]  = tmo_q[i];
            case (slot_q[i])
                FREE: begin
                    if (shoot_d[i]) begin
                        slot_d[i] = LAUNCHING;
                        tmo_d[i]  = '0;
                    end
                end
                LAUNCHING: begin
                    if (!slot_carry[i]) begin
                        slot_d[i] = FLYING;
                    end else if (tmo_q[i] == TMO_W'(LAUNCH_TIMEOUT - 1)) begin
                        slot_d[i] = FREE;
                    end else begin
                        tmo_d[i] = tmo_q[i] + 1'b1;
                    end
                end
                FLYING: begin
                    if (slot_carry[i]) begin
                        slot_d[i] = FREE;
                    end
                end
                default: slot_d[i] = FREE;
            endcase
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            ctrl_q  <= IDLE;
            cd_q    <= '0;
            ptr_q   <= '0;
            shoot_q <= '0;
            ack_q   <= 1'b0;
            drop_q  <= 1'b0;
            dir_q   <= LEFT;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= FREE;
                tmo_q[i]  <= '0;
            end
        end else begin
            ctrl_q  <= ctrl_d;
            cd_q    <= cd_d;
            ptr_q   <= ptr_d;
            shoot_q <= shoot_d;
            ack_q   <= ack_d;
            drop_q  <= drop_d;
            dir_q   <= dir_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= slot_d[i];
                tmo_q[i]  <= tmo_d[i];
            end
        end
    end

    assign shoot        = shoot_q;
    assign fire_ack     = ack_q;
    assign fire_dropped = drop_q;
    assign shot_dir     = dir_q;

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Bench for bullet_pool_ctrl: directed fire sequences; expected shoot/ack/drop events queued and checked by a monitor.
module tb_bullet_pool_ctrl;

    localparam int N = 4;

    logic           frame_clk = 1'b0;
    logic           Reset     = 1'b1;
    logic           fire      = 1'b0;
    logic [1:0]     Direction = 2'b00;
    logic [N-1:0]   slot_carry = '1;
    logic [N-1:0]   shoot;
    logic [1:0]     shot_dir;
    logic [2:0]     slots_free;
    logic           fire_ack;
    logic           fire_dropped;

    typedef struct packed {
        logic [3:0] shoot;
        logic       ack;
        logic       drop;
        logic [1:0] dir;
        logic [2:0] free;
    } ev_t;

    ev_t exp_q[$];
    int  vec_cnt = 0;
    int  err_cnt = 0;
    int  ev_cnt  = 0;

    bullet_pool_ctrl #(
        .NUM_SLOTS       (N),
        .COOLDOWN_FRAMES (8),
        .LAUNCH_TIMEOUT  (4)
    ) dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .fire         (fire),
        .Direction    (Direction),
        .slot_carry   (slot_carry),
        .shoot        (shoot),
        .shot_dir     (shot_dir),
        .slots_free   (slots_free),
        .fire_ack     (fire_ack),
        .fire_dropped (fire_dropped)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check(input string name, input int act, input int req);
        vec_cnt++;
        if (act != req) begin
            err_cnt++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    task automatic expect_ev(input logic [3:0] s, input logic a, input logic d,
                             input logic [1:0] dr, input logic [2:0] f);
        ev_t e;
        e.shoot = s;
        e.ack   = a;
        e.drop  = d;
        e.dir   = dr;
        e.free  = f;
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            ev_t act;
            ev_t e;
            @(negedge frame_clk);
            if (!Reset && (shoot != '0 || fire_ack || fire_dropped)) begin
                act.shoot = shoot;
                act.ack   = fire_ack;
                act.drop  = fire_dropped;
                act.dir   = shot_dir;
                act.free  = slots_free;
                ev_cnt++;
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL unexpected_event: got shoot=%b ack=%b drop=%b dir=%b free=%0d",
                             act.shoot, act.ack, act.drop, act.dir, act.free);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        err_cnt++;
                        $display("FAIL event_%0d: got shoot=%b ack=%b drop=%b dir=%b free=%0d, want shoot=%b ack=%b drop=%b dir=%b free=%0d",
                                 ev_cnt, act.shoot, act.ack, act.drop, act.dir, act.free,
                                 e.shoot, e.ack, e.drop, e.dir, e.free);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d expected events pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        #2;
        check("reset_shoot", shoot, 0);
        check("reset_ack", fire_ack, 0);
        check("reset_drop", fire_dropped, 0);
        check("reset_dir", shot_dir, 0);
        check("reset_free", slots_free, 4);
        tick(2);
        Reset = 1'b0;
        tick(1);

        // first shot goes to slot 0, facing right
        Direction = 2'b01;
        fire = 1'b1;
        expect_ev(4'b0001, 1'b1, 1'b0, 2'b01, 3'd3);
        tick(1);
        tick(1);
        check("t1_shoot_cleared", shoot, 0);
        check("t1_ack_cleared", fire_ack, 0);

        // fire stays held: no second shot; slot 0 times out with carry still 1
        tick(18);
        check("t2_single_shot", ev_cnt, 1);
        check("t2_slot0_timeout", slots_free, 4);
        fire = 1'b0;
        tick(3);

        // cooldown: early edge ignored silently, edge 10 frames later accepted
        Direction = 2'b10;
        fire = 1'b1;
        expect_ev(4'b0010, 1'b1, 1'b0, 2'b10, 3'd3);
        tick(1);
        fire = 1'b0;
        tick(2);
        fire = 1'b1;
        tick(1);
        check("t3_early_no_shoot", shoot, 0);
        check("t3_early_no_drop", fire_dropped, 0);
        fire = 1'b0;
        tick(6);
        Direction = 2'b11;
        fire = 1'b1;
        expect_ev(4'b0100, 1'b1, 1'b0, 2'b11, 3'd3);
        tick(1);
        fire = 1'b0;
        tick(2);

        // reset mid-cooldown, then fill the pool with carry held low
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        slot_carry = '0;
        tick(1);
        for (int k = 0; k < 4; k++) begin
            Direction = 2'(k);
            fire = 1'b1;
            expect_ev(4'(1 << k), 1'b1, 1'b0, 2'(k), 3'(3 - k));
            tick(1);
            fire = 1'b0;
            tick(9);
        end
        check("t4_pool_empty", slots_free, 0);
        Direction = 2'b01;
        fire = 1'b1;
        expect_ev(4'b0000, 1'b0, 1'b1, 2'b11, 3'd0);
        tick(1);
        fire = 1'b0;
        tick(1);
        check("t4_drop_one_frame", fire_dropped, 0);

        // slot 2 returns, is regranted, and times out in LAUNCHING
        slot_carry = 4'b0100;
        tick(2);
        check("t5_slot2_returned", slots_free, 1);
        Direction = 2'b10;
        fire = 1'b1;
        expect_ev(4'b0100, 1'b1, 1'b0, 2'b10, 3'd0);
        tick(1);
        fire = 1'b0;
        check("t5_launching_busy", slots_free, 0);
        tick(3);
        check("t5_launching_hold", slots_free, 0);
        tick(1);
        check("t5_timeout_free", slots_free, 1);

        // reset right after an accept while slots 0 and 1 are flying
        slot_carry = 4'b1100;
        tick(1);
        check("t6_free_before", slots_free, 2);
        tick(5);
        Direction = 2'b00;
        fire = 1'b1;
        tick(1);
        check("t6_shoot_pre_reset", shoot, 8);
        #1;
        Reset = 1'b1;
        fire = 1'b0;
        #1;
        check("t6_reset_shoot", shoot, 0);
        check("t6_reset_free", slots_free, 4);
        check("t6_reset_ack", fire_ack, 0);
        check("t6_reset_dir", shot_dir, 0);
        tick(2);
        Reset = 1'b0;
        slot_carry = '1;
        tick(1);
        Direction = 2'b01;
        fire = 1'b1;
        expect_ev(4'b0001, 1'b1, 1'b0, 2'b01, 3'd3);
        tick(1);
        fire = 1'b0;
        tick(12);

        check("scoreboard_drained", exp_q.size(), 0);
        check("event_count", ev_cnt, 10);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
